// File: rtl/lse_clut_loader.sv
// rtl/lse_clut_loader.sv - CLUT writer: loads correction entries from a stream into the lse_add LUT
// Table storage is flopped with async clear so every PE sees a zeroed table after reset.

module lse_clut_loader #(
  parameter int LUT_SIZE      = 1024,
  parameter int LUT_PRECISION = 10,
  parameter int AW            = $clog2(LUT_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [AW-1:0]            cfg_base,
  input  logic [AW-1:0]            cfg_count,
  input  logic                     cfg_abort,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [LUT_PRECISION-1:0] wr_data,
  output logic [LUT_PRECISION-1:0] lut_table [LUT_SIZE],
  output logic                     table_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  input  logic [AW-1:0]            rd_addr,
  output logic [LUT_PRECISION-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                     state_q;
  logic [AW-1:0]              addr_q;
  logic [AW-1:0]              addr_d;
  logic [AW:0]                remaining_q;
  logic [AW:0]                remaining_d;
  logic [LUT_PRECISION-1:0]   lut_q [LUT_SIZE];
  logic                       table_valid_q;
  logic                       cfg_err_q;
  logic [LUT_PRECISION-1:0]   rd_data_q;
  logic                       beat;

  // wr_ready depends on state only, so no path exists from wr_valid back to wr_ready.
  assign wr_ready    = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign beat        = (state_q == LOAD) && wr_valid;
  assign addr_d      = addr_q + AW'(1);
  assign remaining_d = remaining_q - (AW+1)'(1);

  assign lut_table   = lut_q;
  assign table_valid = table_valid_q;
  assign cfg_err     = cfg_err_q;
  assign rd_data     = rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      table_valid_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      rd_data_q     <= '0;
      for (int i = 0; i < LUT_SIZE; i++) lut_q[i] <= '0;
    end else begin
      cfg_err_q <= cfg_start && (state_q != IDLE);
      rd_data_q <= lut_q[rd_addr];
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            addr_q        <= cfg_base;
            remaining_q   <= (cfg_count == '0) ? (AW+1)'(LUT_SIZE) : {1'b0, cfg_count};
            table_valid_q <= 1'b0;
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            lut_q[addr_q] <= wr_data;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
          end
          // Abort wins over completion; a beat in the abort cycle is still kept.
          if (cfg_abort) state_q <= IDLE;
          else if (beat && remaining_q == (AW+1)'(1)) state_q <= DONE;
        end
        DONE: begin
          table_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lse_clut_loader.sv
// tb/tb_lse_clut_loader.sv - self-checking bench for lse_clut_loader
module tb_lse_clut_loader;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic [9:0] cfg_base;
  logic [9:0] cfg_count;
  logic       cfg_abort;
  logic       wr_valid;
  logic       wr_ready;
  logic [9:0] wr_data;
  logic [9:0] lut_table [1024];
  logic       table_valid;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [9:0] rd_addr;
  logic [9:0] rd_data;

  lse_clut_loader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .cfg_abort(cfg_abort), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .lut_table(lut_table),
    .table_valid(table_valid), .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int base;
    int cnt;
    int stall;      // 0 none, 1 every other cycle, 2 random
    int dmode;      // 0 data=addr, 1 random, 2 17*(beat+1)
    int amode;      // 0 none, 1 abort without beat, 2 abort with beat
    int aat;        // beat index at which abort is raised
    bit inj;        // cfg_start during LOAD and DONE
    int exp_beats;
    bit exp_done;
    bit exp_tv;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] ref_mem [1024];
  bit         ref_tv;
  int         n_chk;
  int         n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cmp_table(input string nm);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 1024; i++)
      if (lut_table[i] !== ref_mem[i]) diffs++;
    chk(nm, 32'(diffs), 32'd0);
  endtask

  task automatic rd_check(input int a);
    rd_addr = 10'(a);
    @(posedge clk); #1;
    chk("readback", 32'(rd_data), 32'(ref_mem[a]));
  endtask

  task automatic run_load(input vec_t v);
    int n, beats, a, done_cnt, bad, budget;
    bit valid, abort, start_now, injected, accept, inj_done;
    logic [9:0] dat, old;
    n = (v.cnt == 0) ? 1024 : v.cnt;
    cfg_base  = 10'(v.base);
    cfg_count = 10'(v.cnt);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_tv", 32'(table_valid), 32'd0);
    chk("start_err", 32'(cfg_err), 32'd0);
    beats = 0; a = v.base; done_cnt = 0; bad = 0; injected = 0;
    budget = 4 * n + 20;
    for (int cyc = 0; cyc < budget; cyc++) begin
      case (v.stall)
        0:       valid = 1'b1;
        1:       valid = (cyc % 2 == 0);
        default: valid = ($urandom_range(2) != 0);
      endcase
      valid = valid && (beats < n);
      abort = (v.amode != 0) && (beats == v.aat);
      if (abort) valid = (v.amode == 2);
      start_now = v.inj && (beats == 2) && !injected;
      if (start_now) injected = 1'b1;
      case (v.dmode)
        0:       dat = a[9:0];
        1:       dat = 10'($urandom);
        default: dat = 10'((beats + 1) * 17);
      endcase
      wr_valid = valid; wr_data = dat; cfg_abort = abort;
      cfg_start = start_now; rd_addr = a[9:0];
      old = ref_mem[a];
      if (wr_ready !== 1'b1) bad++;
      accept = valid && (wr_ready === 1'b1);
      @(posedge clk); #1;
      wr_valid = 1'b0; cfg_abort = 1'b0; cfg_start = 1'b0;
      if (accept) begin
        ref_mem[a] = dat;
        a = (a + 1) % 1024;
        beats++;
      end
      if (rd_data !== old) bad++;
      if (cfg_err !== start_now) bad++;
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b1) break;
    end
    chk("leave_load", 32'(busy), 32'd0);
    chk("beats", 32'(beats), 32'(v.exp_beats));
    chk("done_pulses", 32'(done_cnt), 32'(v.exp_done));
    chk("load_cycle_flags", 32'(bad), 32'd0);
    chk("ready_off", 32'(wr_ready), 32'd0);
    inj_done  = v.inj && v.exp_done;
    cfg_start = inj_done;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("err_in_done", 32'(cfg_err), 32'(inj_done));
    chk("done_clear", 32'(done), 32'd0);
    chk("tv_after", 32'(table_valid), 32'(v.exp_tv));
    chk("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("err_clear", 32'(cfg_err), 32'd0);
    ref_tv = v.exp_tv;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   c;
    n_chk = 0; n_pass = 0; ref_tv = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst = 1'b1; cfg_start = 0; cfg_base = 0; cfg_count = 0; cfg_abort = 0;
    wr_valid = 1'b1; wr_data = 10'h155; rd_addr = 10'h3FF;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_tv", 32'(table_valid), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    cmp_table("rst_table");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(wr_ready), 32'd0);
    chk("idle_no_load", 32'(busy), 32'd0);
    wr_valid = 1'b0;

    vecs.push_back('{0,     0, 0, 0, 0, 0, 0, 1024, 1, 1});
    vecs.push_back('{'h3FE, 4, 1, 2, 0, 0, 0, 4,    1, 1});
    vecs.push_back('{'h10,  8, 0, 1, 1, 3, 0, 3,    0, 0});
    vecs.push_back('{'h100, 6, 2, 1, 0, 0, 1, 6,    1, 1});
    vecs.push_back('{'h200, 1, 0, 1, 2, 0, 0, 1,    0, 0});
    for (int k = 0; k < 6; k++) begin
      c = $urandom_range(40, 1);
      v.base = $urandom_range(1023); v.cnt = c; v.stall = 2; v.dmode = 1;
      v.amode = $urandom_range(2); v.aat = $urandom_range(c - 1, 0);
      v.inj = 1'($urandom_range(1));
      v.exp_beats = (v.amode == 0) ? c : (v.amode == 1) ? v.aat : v.aat + 1;
      v.exp_done  = (v.amode == 0);
      v.exp_tv    = (v.amode == 0);
      vecs.push_back(v);
    end

    foreach (vecs[i]) begin
      run_load(vecs[i]);
      cmp_table("table_after_load");
      if (i == 0) begin
        rd_addr = 10'h3FF;
        @(posedge clk); #1;
        chk("rd_3ff", 32'(rd_data), 32'h3FF);
      end
    end

    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_tv", 32'(table_valid), 32'(ref_tv));

    cfg_base = 10'h20; cfg_count = 10'd10; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      wr_valid = 1'b1; wr_data = 10'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(wr_ready), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(cfg_err), 32'd0);
    chk("arst_tv", 32'(table_valid), 32'd0);
    chk("arst_rd", 32'(rd_data), 32'd0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    cmp_table("arst_table");
    wr_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;

    v = '{'h37, 20, 2, 1, 0, 0, 0, 20, 1, 1};
    run_load(v);
    cmp_table("post_rst_table");
    for (int k = 0; k < 4; k++) rd_check($urandom_range(1023));
    rd_check('h37);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
